// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one combinational ALU.
// A round-robin arbiter accepts one operation at a time. Operands are latched on
// the accept edge and held on the ALU inputs for EXEC_CYCLES cycles. The result is
// registered onto rsp_data and returned to the winning requester with a
// valid/ready handshake.

// Combinational ALU (MIPS-style function codes); unknown codes return zero.
module alu #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   operation,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] ALUResult
);

    localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(4'b1100);

    // Decode the operation code and compute the two's-complement result.
    always_comb begin
        ALUResult = {DATA_W{1'b0}};
        case (operation)
            OP_AND:  ALUResult = A & B;
            OP_OR:   ALUResult = A | B;
            OP_ADD:  ALUResult = A + B;
            OP_SUB:  ALUResult = A - B;
            OP_SLT:  ALUResult = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR:  ALUResult = ~(A | B);
            default: ALUResult = {DATA_W{1'b0}};
        endcase
    end

endmodule

module alu_share_arbiter #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Countdown only needs to hold EXEC_CYCLES-1.
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

    logic [1:0]        state_r;
    logic [CW-1:0]     cnt_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              last_grant_r;
    logic              grant_id_r;
    logic              busy_r;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [CNT_W-1:0]  op_count_r;

    logic              winner_s;
    logic              accept_s;
    logic              rsp_fire_s;
    logic              capture_s;
    logic [DATA_W-1:0] alu_result_s;

    // The shared ALU only ever sees the latched operands, so its inputs stay
    // stable for the whole execution window regardless of requester activity.
    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .operation (op_r),
        .A         (a_r),
        .B         (b_r),
        .ALUResult (alu_result_s)
    );

    // Round-robin winner: a lone requester wins; on a tie, the one not served last.
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_s = ~last_grant_r;
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign req0_ready = (state_r == ST_IDLE) && req0_valid && !winner_s;
    assign req1_ready = (state_r == ST_IDLE) && req1_valid &&  winner_s;
    assign accept_s   = req0_ready || req1_ready;
    assign rsp_fire_s = (rsp0_valid_r && rsp0_ready) || (rsp1_valid_r && rsp1_ready);
    assign capture_s  = (state_r == ST_EXEC) && (cnt_r == {CW{1'b0}});

    // Sequencer: IDLE -> EXEC (count down the hold window) -> RESP -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_EXEC;
                        cnt_r   <= EXEC_LOAD;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CW'(1'b1);
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Latch the winner's operands and identity on the accept edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= {OP_W{1'b0}};
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            op_r         <= winner_s ? req1_op : req0_op;
            a_r          <= winner_s ? req1_a  : req0_a;
            b_r          <= winner_s ? req1_b  : req0_b;
            grant_id_r   <= winner_s;
            last_grant_r <= winner_s;
        end
    end

    // Capture the ALU result and raise the owner's response valid until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else if (capture_s) begin
            rsp_data_r   <= alu_result_s;
            rsp0_valid_r <= ~grant_id_r;
            rsp1_valid_r <=  grant_id_r;
        end else if (rsp_fire_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end
    end

    // Busy flag mirrors "not IDLE": set on accept, cleared when the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else if (accept_s) begin
            busy_r <= 1'b1;
        end else if (rsp_fire_s) begin
            busy_r <= 1'b0;
        end
    end

    // Completed-response counter; wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (rsp_fire_s) begin
            op_count_r <= op_count_r + CNT_W'(1'b1);
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp_data   = rsp_data_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed table, hand-written corner
// sequences (fairness, back-pressure, mid-operation reset, long execution window
// with a narrow counter) and randomized traffic against a reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        busy, grant_id;
    logic [15:0] op_count;

    logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [3:0]  b_req0_op, b_req1_op;
    logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic        b_rsp0_valid, b_rsp1_valid, b_rsp0_ready, b_rsp1_ready;
    logic [31:0] b_rsp_data;
    logic        b_busy, b_grant_id;
    logic [3:0]  b_op_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    alu_share_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    alu_share_arbiter #(.EXEC_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_a(b_req0_a), .req0_b(b_req0_b),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_a(b_req1_a), .req1_b(b_req1_b),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
        .rsp_data(b_rsp_data), .busy(b_busy), .grant_id(b_grant_id), .op_count(b_op_count)
    );

    typedef struct {
        bit          who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          delay;
    } vec_t;

    // Reference ALU written from the op-code meanings with signed arithmetic.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return 32'(sa + sb);
            4'd6:    return 32'(sa - sb);
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_op = 4'd0; req1_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_rsp0_ready = 1'b0; b_rsp1_ready = 1'b0;
        b_req0_op = 4'd0; b_req1_op = 4'd0; b_req0_a = 32'd0; b_req0_b = 32'd0;
        b_req1_a = 32'd0; b_req1_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the default instance, entered and left at posedge+1.
    task automatic do_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int delay);
        int n;
        int lat;
        if (who) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, who ? req1_ready : req0_ready}, 32'd1);
        check("other_ready", {31'd0, who ? req0_ready : req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        // Operands change after acceptance; the result must not see them.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_op = 4'(~op); req1_op = 4'(~op);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(rsp0_valid || rsp1_valid) && lat < 20);
        check("latency", 32'(lat), 32'd1);
        check("rsp_valid_own", {31'd0, who ? rsp1_valid : rsp0_valid}, 32'd1);
        check("rsp_valid_other", {31'd0, who ? rsp0_valid : rsp1_valid}, 32'd0);
        check("rsp_data", rsp_data, exp);
        check("grant_id", {31'd0, grant_id}, {31'd0, who});
        for (int d = 0; d < delay; d++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check("hold_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, who ? rsp1_valid : rsp0_valid}, 32'd1);
            check("hold_data", rsp_data, exp);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("rsp_done", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("op_count", {16'd0, op_count}, {16'd0, exp_count});
    endtask

    vec_t        vecs[5];
    logic [3:0]  op_pool[7];
    logic [3:0]  cnt4;
    logic [31:0] exp_b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 197 = 0x000000C5, -237 = 0xFFFFFF13
        vecs[0] = '{1'b0, 4'b0010, 32'd197, -32'sd237, 32'hFFFFFFD8, 0};  // -40
        vecs[1] = '{1'b1, 4'b0110, 32'd197, -32'sd237, 32'd434, 0};
        vecs[2] = '{1'b0, 4'b0000, 32'd197, -32'sd237, 32'h00000001, 1};  // C5 & 13
        vecs[3] = '{1'b1, 4'b0001, 32'd197, -32'sd237, 32'hFFFFFFD7, 5};  // -41
        vecs[4] = '{1'b0, 4'b0111, -32'sd237, 32'd197, 32'd1, 2};         // signed less-than
        op_pool = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd9};

        do_reset();
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy_grant", {30'd0, busy, grant_id}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);

        // Long execution window with a 4-bit counter: latency 3 and wrap at 16.
        cnt4 = 4'd0;
        for (int i = 0; i < 16; i++) begin
            int n;
            int lat;
            b_req1_op = 4'd2; b_req1_a = 32'(i * 1000); b_req1_b = $urandom;
            exp_b = alu_ref(4'd2, b_req1_a, b_req1_b);
            b_req1_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!b_req1_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b_accept", {31'd0, b_req1_ready}, 32'd1);
            @(posedge clk);
            #1;
            b_req1_valid = 1'b0; b_req1_a = $urandom; b_req1_b = $urandom; b_req1_op = 4'd0;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
                if (!b_rsp1_valid) check("b_busy_exec", {31'd0, b_busy}, 32'd1);
            end while (!b_rsp1_valid && lat < 20);
            check("b_latency", 32'(lat), 32'd3);
            check("b_rsp_data", b_rsp_data, exp_b);
            b_rsp1_ready = 1'b1;
            @(posedge clk);
            #1;
            b_rsp1_ready = 1'b0;
            cnt4 = cnt4 + 4'd1;
            check("b_op_count", {28'd0, b_op_count}, {28'd0, cnt4});
        end

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].delay);
        end

        // Fairness: both valid straight out of reset, grants alternate starting with 0.
        do_reset();
        req0_op = 4'b0000; req0_a = 32'd197; req0_b = -32'sd237;
        req1_op = 4'b0001; req1_a = 32'd197; req1_b = -32'sd237;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("fair_grant", {30'd0, req0_ready, req1_ready}, (i % 2) ? 32'd1 : 32'd2);
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!(rsp0_valid || rsp1_valid) && n < 20);
            check("fair_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, (i % 2) ? 32'd1 : 32'd2);
            check("fair_rsp_data", rsp_data, (i % 2) ? alu_ref(4'b0001, 32'd197, -32'sd237)
                                                     : alu_ref(4'b0000, 32'd197, -32'sd237));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_count = 16'd4;
        check("fair_op_count", {16'd0, op_count}, {16'd0, exp_count});

        // Reset asserted while an operation is executing.
        req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        @(negedge clk);
        check("midrst_accept", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        check("midrst_op_count", {16'd0, op_count}, 32'd0);
        check("midrst_grant", {31'd0, grant_id}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("midrst_op_count_after", {16'd0, op_count}, 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            bit          who;
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            who = 1'($urandom_range(0, 1));
            op  = op_pool[$urandom_range(0, 6)];
            a   = $urandom;
            b   = $urandom;
            do_op(who, op, a, b, alu_ref(op, a, b), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
